// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the configurable up/down counter.
// Range arithmetic is done at a fixed maximum width and then cast down by the user.
package updown_counter_pkg;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam int MAX_WIDTH = 32;
    localparam logic [MAX_WIDTH:0] RANGE_ONE = 1;

    // Inclusive size of [lo, hi], one bit wider than the bounds so a full range fits.
    function automatic logic [MAX_WIDTH:0] range_size(
        input logic [MAX_WIDTH-1:0] lo,
        input logic [MAX_WIDTH-1:0] hi
    );
        return {1'b0, hi} - {1'b0, lo} + RANGE_ONE;
    endfunction

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count computation: step up/down with saturate or wrap at the bounds.
// All comparisons are made one bit wider than the count so nothing overflows silently.
module updown_next_calc
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] bound_min,
    input  logic [WIDTH-1:0] bound_max,
    input  logic [WIDTH-1:0] step,
    input  logic             wrap,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] next_count,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] min_ext;
    logic [WIDTH:0] max_ext;
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] range;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] above_min;

    assign count_ext = {1'b0, count};
    assign min_ext   = {1'b0, bound_min};
    assign max_ext   = {1'b0, bound_max};
    assign step_ext  = {1'b0, step};
    assign range     = (WIDTH+1)'(range_size(MAX_WIDTH'(bound_min), MAX_WIDTH'(bound_max)));
    assign sum       = count_ext + step_ext;
    assign above_min = count_ext - min_ext;

    always_comb begin
        next_count = count;
        ovf        = 1'b0;
        unf        = 1'b0;
        if (inc && !dec) begin
            if (sum <= max_ext) begin
                next_count = WIDTH'(sum);
            end else begin
                ovf        = 1'b1;
                next_count = (wrap == MODE_WRAP) ? WIDTH'(sum - range) : bound_max;
            end
        end else if (dec && !inc) begin
            if (above_min >= step_ext) begin
                next_count = WIDTH'(count_ext - step_ext);
            end else begin
                unf = 1'b1;
                // Adding the range before subtracting keeps the intermediate non-negative.
                next_count = (wrap == MODE_WRAP) ? WIDTH'(count_ext + range - step_ext) : bound_min;
            end
        end
    end

endmodule

// File: rtl/updown_counter_cfg.sv
// Configurable up/down counter: run-time bounds, step and wrap mode loaded via a strobe,
// with rejected loads flagged and overflow/underflow reported as one-cycle pulses.
module updown_counter_cfg
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int RST_WRAP = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] cfg_min,
    input  logic [WIDTH-1:0] cfg_max,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic             cfg_wrap,
    input  logic             count_inc,
    input  logic             count_dec,
    output logic [WIDTH-1:0] count,
    output logic             flag_count_max,
    output logic             flag_count_min,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             cfg_err
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] step_q;
    logic             wrap_q;
    logic             ovf_q;
    logic             unf_q;
    logic             cfg_err_q;

    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    logic             unf_next;
    logic [WIDTH:0]   cfg_range;
    logic             cfg_valid;

    updown_next_calc #(
        .WIDTH(WIDTH)
    ) u_next_calc (
        .count      (count_q),
        .bound_min  (min_q),
        .bound_max  (max_q),
        .step       (step_q),
        .wrap       (wrap_q),
        .inc        (count_inc),
        .dec        (count_dec),
        .next_count (count_next),
        .ovf        (ovf_next),
        .unf        (unf_next)
    );

    // A step no larger than the range keeps every wrapped result inside the bounds.
    assign cfg_range = (WIDTH+1)'(range_size(MAX_WIDTH'(cfg_min), MAX_WIDTH'(cfg_max)));
    assign cfg_valid = (cfg_min <= cfg_max) && (cfg_step != '0) && ({1'b0, cfg_step} <= cfg_range);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            min_q     <= '0;
            max_q     <= '1;
            step_q    <= WIDTH'(1);
            wrap_q    <= 1'(RST_WRAP);
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else if (load_en) begin
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cfg_err_q <= !cfg_valid;
            if (cfg_valid) begin
                count_q <= cfg_min;
                min_q   <= cfg_min;
                max_q   <= cfg_max;
                step_q  <= cfg_step;
                wrap_q  <= cfg_wrap;
            end
        end else begin
            count_q   <= count_next;
            ovf_q     <= ovf_next;
            unf_q     <= unf_next;
            cfg_err_q <= 1'b0;
        end
    end

    assign count          = count_q;
    assign flag_count_max = (count_q == max_q);
    assign flag_count_min = (count_q == min_q);
    assign ovf_pulse      = ovf_q;
    assign unf_pulse      = unf_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_updown_counter_cfg.sv
// Directed self-checking bench for updown_counter_cfg at WIDTH=4, saturate reset mode.
module tb_updown_counter_cfg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_en;
    logic [3:0] cfg_min;
    logic [3:0] cfg_max;
    logic [3:0] cfg_step;
    logic       cfg_wrap;
    logic       count_inc;
    logic       count_dec;
    logic [3:0] count;
    logic       flag_count_max;
    logic       flag_count_min;
    logic       ovf_pulse;
    logic       unf_pulse;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    updown_counter_cfg #(
        .WIDTH(4),
        .RST_WRAP(0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_en        (load_en),
        .cfg_min        (cfg_min),
        .cfg_max        (cfg_max),
        .cfg_step       (cfg_step),
        .cfg_wrap       (cfg_wrap),
        .count_inc      (count_inc),
        .count_dec      (count_dec),
        .count          (count),
        .flag_count_max (flag_count_max),
        .flag_count_min (flag_count_min),
        .ovf_pulse      (ovf_pulse),
        .unf_pulse      (unf_pulse),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] mn, input logic [3:0] mx,
                           input logic [3:0] st, input logic wr);
        cfg_min = mn; cfg_max = mx; cfg_step = st; cfg_wrap = wr;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_en = 1'b0; count_inc = 1'b0; count_dec = 1'b0;
        cfg_min = '0; cfg_max = '0; cfg_step = '0; cfg_wrap = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (count !== 4'd0 || flag_count_min !== 1'b1 || flag_count_max !== 1'b0 ||
            ovf_pulse !== 1'b0 || unf_pulse !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d fmin=%b fmax=%b ovf=%b unf=%b err=%b, required 0 1 0 0 0 0",
                     count, flag_count_min, flag_count_max, ovf_pulse, unf_pulse, cfg_err);
        end
        $display("reset: count=%0d fmin=%b fmax=%b", count, flag_count_min, flag_count_max);
    endtask

    task automatic test_sat_full();
        count_inc = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (count !== 4'(i) || ovf_pulse !== 1'b0) begin
                errors++;
                $display("FAIL sat_full_inc: count=%0d ovf=%b, required %0d 0", count, ovf_pulse, i);
            end
        end
        tick();
        checks++;
        if (count !== 4'd15 || ovf_pulse !== 1'b1 || flag_count_max !== 1'b1) begin
            errors++;
            $display("FAIL sat_full_at_max: count=%0d ovf=%b fmax=%b, required 15 1 1",
                     count, ovf_pulse, flag_count_max);
        end
        count_inc = 1'b0;
        tick();
        checks++;
        if (count !== 4'd15 || ovf_pulse !== 1'b0) begin
            errors++;
            $display("FAIL sat_full_pulse_clear: count=%0d ovf=%b, required 15 0", count, ovf_pulse);
        end
        $display("sat_full: count=%0d", count);
    endtask

    task automatic test_sat_bounded();
        logic [3:0] inc_exp [4] = '{4'd5, 4'd7, 4'd9, 4'd9};
        logic       inc_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] dec_exp [5] = '{4'd7, 4'd5, 4'd3, 4'd3, 4'd3};
        logic       dec_unf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_load(4'd3, 4'd9, 4'd2, 1'b0);
        checks++;
        if (count !== 4'd3 || cfg_err !== 1'b0 || flag_count_min !== 1'b1) begin
            errors++;
            $display("FAIL sat_load: count=%0d err=%b fmin=%b, required 3 0 1", count, cfg_err, flag_count_min);
        end
        count_inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== inc_exp[i] || ovf_pulse !== inc_ovf[i]) begin
                errors++;
                $display("FAIL sat_bnd_inc%0d: count=%0d ovf=%b, required %0d %b",
                         i, count, ovf_pulse, inc_exp[i], inc_ovf[i]);
            end
        end
        count_inc = 1'b0;
        count_dec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (count !== dec_exp[i] || unf_pulse !== dec_unf[i] || ovf_pulse !== 1'b0) begin
                errors++;
                $display("FAIL sat_bnd_dec%0d: count=%0d unf=%b ovf=%b, required %0d %b 0",
                         i, count, unf_pulse, ovf_pulse, dec_exp[i], dec_unf[i]);
            end
        end
        count_dec = 1'b0;
        $display("sat_bounded: count=%0d", count);
    endtask

    task automatic test_wrap_bounded();
        logic [3:0] inc_exp [4] = '{4'd5, 4'd7, 4'd9, 4'd4};
        logic       inc_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_load(4'd3, 4'd9, 4'd2, 1'b1);
        count_inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== inc_exp[i] || ovf_pulse !== inc_ovf[i]) begin
                errors++;
                $display("FAIL wrap_bnd_inc%0d: count=%0d ovf=%b, required %0d %b",
                         i, count, ovf_pulse, inc_exp[i], inc_ovf[i]);
            end
        end
        count_inc = 1'b0;
        count_dec = 1'b1;
        tick();
        count_dec = 1'b0;
        checks++;
        if (count !== 4'd9 || unf_pulse !== 1'b1 || ovf_pulse !== 1'b0) begin
            errors++;
            $display("FAIL wrap_bnd_dec: count=%0d unf=%b ovf=%b, required 9 1 0", count, unf_pulse, ovf_pulse);
        end
        $display("wrap_bounded: count=%0d", count);
    endtask

    task automatic test_invalid_load();
        logic [3:0] bad_min  [3] = '{4'd10, 4'd3, 4'd3};
        logic [3:0] bad_max  [3] = '{4'd5,  4'd9, 4'd9};
        logic [3:0] bad_step [3] = '{4'd1,  4'd0, 4'd8};
        do_load(4'd3, 4'd9, 4'd1, 1'b0);
        count_inc = 1'b1;
        tick();
        tick();
        count_inc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_load(bad_min[i], bad_max[i], bad_step[i], 1'b1);
            checks++;
            if (cfg_err !== 1'b1 || count !== 4'd5) begin
                errors++;
                $display("FAIL invalid_load%0d: err=%b count=%0d, required 1 5", i, cfg_err, count);
            end
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0 || count !== 4'd5) begin
            errors++;
            $display("FAIL invalid_err_clear: err=%b count=%0d, required 0 5", cfg_err, count);
        end
        // Retained bounds, step 1 and saturate mode show up as 4, 3, then held at 3.
        count_dec = 1'b1;
        tick();
        tick();
        checks++;
        if (count !== 4'd3 || flag_count_min !== 1'b1 || unf_pulse !== 1'b0) begin
            errors++;
            $display("FAIL invalid_kept_min: count=%0d fmin=%b unf=%b, required 3 1 0",
                     count, flag_count_min, unf_pulse);
        end
        tick();
        count_dec = 1'b0;
        checks++;
        if (count !== 4'd3 || unf_pulse !== 1'b1) begin
            errors++;
            $display("FAIL invalid_kept_sat: count=%0d unf=%b, required 3 1", count, unf_pulse);
        end
        do_load(4'd3, 4'd9, 4'd7, 1'b1);
        checks++;
        if (cfg_err !== 1'b0 || count !== 4'd3) begin
            errors++;
            $display("FAIL step_eq_range_load: err=%b count=%0d, required 0 3", cfg_err, count);
        end
        count_inc = 1'b1;
        tick();
        count_inc = 1'b0;
        checks++;
        if (count !== 4'd3 || ovf_pulse !== 1'b1) begin
            errors++;
            $display("FAIL step_eq_range_wrap: count=%0d ovf=%b, required 3 1", count, ovf_pulse);
        end
        $display("invalid_load: count=%0d", count);
    endtask

    task automatic test_full_wrap();
        do_load(4'd0, 4'd15, 4'd1, 1'b1);
        count_dec = 1'b1;
        tick();
        count_dec = 1'b0;
        checks++;
        if (count !== 4'd15 || unf_pulse !== 1'b1 || flag_count_max !== 1'b1) begin
            errors++;
            $display("FAIL full_wrap_dec: count=%0d unf=%b fmax=%b, required 15 1 1",
                     count, unf_pulse, flag_count_max);
        end
        count_inc = 1'b1;
        tick();
        count_inc = 1'b0;
        checks++;
        if (count !== 4'd0 || ovf_pulse !== 1'b1 || unf_pulse !== 1'b0) begin
            errors++;
            $display("FAIL full_wrap_inc: count=%0d ovf=%b unf=%b, required 0 1 0", count, ovf_pulse, unf_pulse);
        end
        $display("full_wrap: count=%0d", count);
    endtask

    task automatic test_simultaneous();
        count_inc = 1'b1;
        count_dec = 1'b1;
        tick();
        checks++;
        if (count !== 4'd0 || ovf_pulse !== 1'b0 || unf_pulse !== 1'b0) begin
            errors++;
            $display("FAIL inc_dec_hold: count=%0d ovf=%b unf=%b, required 0 0 0", count, ovf_pulse, unf_pulse);
        end
        count_dec = 1'b0;
        do_load(4'd2, 4'd12, 4'd3, 1'b0);
        checks++;
        if (count !== 4'd2 || ovf_pulse !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL load_over_inc: count=%0d ovf=%b err=%b, required 2 0 0", count, ovf_pulse, cfg_err);
        end
        tick();
        tick();
        checks++;
        if (count !== 4'd8) begin
            errors++;
            $display("FAIL load_then_inc: count=%0d, required 8", count);
        end
        count_inc = 1'b0;
        reset_n = 1'b0;
        cfg_min = 4'd4; cfg_max = 4'd6; cfg_step = 4'd2; cfg_wrap = 1'b1;
        load_en = 1'b1;
        tick();
        reset_n = 1'b1;
        load_en = 1'b0;
        checks++;
        if (count !== 4'd0 || flag_count_min !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_load: count=%0d fmin=%b err=%b, required 0 1 0", count, flag_count_min, cfg_err);
        end
        count_inc = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
        end
        checks++;
        if (count !== 4'd15 || flag_count_max !== 1'b1) begin
            errors++;
            $display("FAIL reset_defaults: count=%0d fmax=%b, required 15 1", count, flag_count_max);
        end
        tick();
        count_inc = 1'b0;
        checks++;
        if (count !== 4'd15 || ovf_pulse !== 1'b1) begin
            errors++;
            $display("FAIL reset_sat_mode: count=%0d ovf=%b, required 15 1", count, ovf_pulse);
        end
        $display("simultaneous: count=%0d", count);
    endtask

    initial begin
        test_reset();
        test_sat_full();
        test_sat_bounded();
        test_wrap_bounded();
        test_invalid_load();
        test_full_wrap();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
